// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with a variable-latency memory handshake.
//
// Drives the PC/IR/MDR/ALUOut/RegisterFile/ALU/memory-mux controls of the
// multi-cycle datapath. Memory accesses in FETCH and MEM_ACC hold mem_req
// until mem_ack, with an optional wait-state timeout that sends the FSM to HALT.
// A retired-instruction counter increments on the edge leaving each
// instruction's last state.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct       IR[31:26], IR[5:0]
//   alu_zero            ALU zero flag (branch resolution)
//   mem_ack             memory done; read data valid in the same cycle
//   mem_req/read/write  memory request and strobes
//   iord                1 = address from PC, 0 = from ALUOut
//   ir_write, pc_write  IR / PC load enables
//   pcsrc               00 ALUOut, 01 ALU result, 10 rs, 11 jump target
//   reg_write, regdst   register-file write, dest 00 $31 / 01 rt / 10 rd
//   memtoreg            1 = MDR, 0 = ALUOut
//   alusrca, alusrcb    ALU operand selects
//   aluop               ALU operation code
//   extop, luiop        sign-extend select, lui immediate shift
//   retired             retired-instruction count (wraps)
//   halted              FSM is in HALT
//   mem_err, illegal    sticky timeout / illegal-instruction flags
//
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap illegal instructions
// into HALT. When undefined, illegal instructions retire as NOPs.

module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pcsrc,
  output logic             reg_write,
  output logic [1:0]       regdst,
  output logic             memtoreg,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       aluop,
  output logic             extop,
  output logic             luiop,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             mem_err,
  output logic             illegal
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluR    = 4'b0010;
  localparam logic [3:0] AluAnd  = 4'b0011;
  localparam logic [3:0] AluOr   = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110;
  localparam logic [3:0] AluLui  = 4'b0111;

  // Last wait count before a missing ack becomes a timeout.
  localparam logic [TO_W-1:0] ToLast = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StWbR, StExecI, StWbI,
    StBranch, StMemAddr, StMemAcc, StMemWb, StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q;
  logic              mem_err_q;
  logic              retire, to_hit, timeout_now, illegal_insn, funct_ok;

  logic       ctl_mem_req, ctl_mem_read, ctl_mem_write, ctl_iord, ctl_ir_write, ctl_pc_write;
  logic [1:0] ctl_pcsrc, ctl_regdst, ctl_alusrca, ctl_alusrcb;
  logic       ctl_reg_write, ctl_memtoreg, ctl_extop, ctl_luiop;
  logic [3:0] ctl_aluop;

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q, trap;
`endif

  assign timeout_now = (MEM_TIMEOUT != 0) && (wait_q == ToLast);

  always_comb begin
    unique case (funct)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B: funct_ok = 1'b1;
      default:      funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    to_hit        = 1'b0;
    illegal_insn  = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    trap          = 1'b0;
`endif
    ctl_mem_req   = 1'b0;
    ctl_mem_read  = 1'b0;
    ctl_mem_write = 1'b0;
    ctl_iord      = 1'b0;
    ctl_ir_write  = 1'b0;
    ctl_pc_write  = 1'b0;
    ctl_pcsrc     = 2'b00;
    ctl_reg_write = 1'b0;
    ctl_regdst    = 2'b00;
    ctl_memtoreg  = 1'b0;
    ctl_alusrca   = 2'b00;
    ctl_alusrcb   = 2'b00;
    ctl_aluop     = AluAdd;
    ctl_extop     = 1'b0;
    ctl_luiop     = 1'b0;

    unique case (state_q)
      StFetch: begin
        ctl_mem_req  = 1'b1;
        ctl_mem_read = 1'b1;
        ctl_iord     = 1'b1;
        ctl_alusrcb  = 2'b11;
        ctl_pcsrc    = 2'b01;
        if (mem_ack) begin
          ctl_ir_write = 1'b1;
          ctl_pc_write = 1'b1;
          state_d      = StDecode;
        end else if (timeout_now) begin
          to_hit  = 1'b1;
          state_d = StHalt;
        end
      end

      StDecode: begin
        // Branch target computed speculatively into ALUOut.
        ctl_alusrcb = 2'b10;
        ctl_extop   = 1'b1;
        unique case (opcode)
          OpJ, OpJal: begin
            ctl_pc_write = 1'b1;
            ctl_pcsrc    = 2'b11;
            // ALUOut still holds PC+4 from FETCH, so jal links from it.
            ctl_reg_write = (opcode == OpJal);
            retire        = 1'b1;
            state_d       = StFetch;
          end
          OpRtype: begin
            if (funct == 6'h08) begin
              ctl_pc_write = 1'b1;
              ctl_pcsrc    = 2'b10;
              retire       = 1'b1;
              state_d      = StFetch;
            end else if (funct_ok) begin
              state_d = StExecR;
            end else begin
              illegal_insn = 1'b1;
            end
          end
          OpBeq, OpBne: state_d = StBranch;
          OpLw, OpSw:   state_d = StMemAddr;
          OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpLui: state_d = StExecI;
          default: illegal_insn = 1'b1;
        endcase
        if (illegal_insn) begin
`ifdef MC_ILLEGAL_TRAP_EN
          trap    = 1'b1;
          state_d = StHalt;
`else
          retire  = 1'b1;
          state_d = StFetch;
`endif
        end
      end

      StExecR: begin
        ctl_aluop   = AluR;
        ctl_alusrca = (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) ? 2'b01 : 2'b11;
        state_d     = StWbR;
      end

      StWbR: begin
        ctl_reg_write = 1'b1;
        ctl_regdst    = 2'b10;
        retire        = 1'b1;
        state_d       = StFetch;
      end

      StExecI: begin
        ctl_alusrca = 2'b11;
        ctl_alusrcb = 2'b01;
        ctl_extop   = !(opcode == OpAndi || opcode == OpOri);
        ctl_luiop   = (opcode == OpLui);
        unique case (opcode)
          OpSlti:  ctl_aluop = AluSlt;
          OpSltiu: ctl_aluop = AluSltu;
          OpAndi:  ctl_aluop = AluAnd;
          OpOri:   ctl_aluop = AluOr;
          OpLui:   ctl_aluop = AluLui;
          default: ctl_aluop = AluAdd;
        endcase
        state_d = StWbI;
      end

      StWbI: begin
        ctl_reg_write = 1'b1;
        ctl_regdst    = 2'b01;
        retire        = 1'b1;
        state_d       = StFetch;
      end

      StBranch: begin
        ctl_alusrca  = 2'b11;
        ctl_aluop    = AluSub;
        ctl_pc_write = (opcode == OpBeq) ? alu_zero : !alu_zero;
        retire       = 1'b1;
        state_d      = StFetch;
      end

      StMemAddr: begin
        ctl_alusrca = 2'b11;
        ctl_alusrcb = 2'b01;
        ctl_extop   = 1'b1;
        state_d     = StMemAcc;
      end

      StMemAcc: begin
        // Same ALU controls as MEM_ADDR keep ALUOut stable across wait states.
        ctl_alusrca   = 2'b11;
        ctl_alusrcb   = 2'b01;
        ctl_extop     = 1'b1;
        ctl_mem_req   = 1'b1;
        ctl_mem_read  = (opcode == OpLw);
        ctl_mem_write = (opcode == OpSw);
        if (mem_ack) begin
          if (opcode == OpSw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StMemWb;
          end
        end else if (timeout_now) begin
          to_hit  = 1'b1;
          state_d = StHalt;
        end
      end

      StMemWb: begin
        ctl_reg_write = 1'b1;
        ctl_regdst    = 2'b01;
        ctl_memtoreg  = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end

      StHalt: state_d = StHalt;

      default: state_d = StFetch;
    endcase
  end

  // Counter only runs while parked in a wait state; any entry starts it at 0.
  always_comb begin
    wait_d = '0;
    if ((state_q == StFetch || state_q == StMemAcc) && state_d == state_q) begin
      wait_d = wait_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (to_hit) mem_err_q <= 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
      if (trap) illegal_q <= 1'b1;
`endif
    end
  end

  // Reset masks every output combinationally so an in-flight request drops at once.
  assign mem_req   = !rst && ctl_mem_req;
  assign mem_read  = !rst && ctl_mem_read;
  assign mem_write = !rst && ctl_mem_write;
  assign iord      = !rst && ctl_iord;
  assign ir_write  = !rst && ctl_ir_write;
  assign pc_write  = !rst && ctl_pc_write;
  assign pcsrc     = rst ? 2'b00 : ctl_pcsrc;
  assign reg_write = !rst && ctl_reg_write;
  assign regdst    = rst ? 2'b00 : ctl_regdst;
  assign memtoreg  = !rst && ctl_memtoreg;
  assign alusrca   = rst ? 2'b00 : ctl_alusrca;
  assign alusrcb   = rst ? 2'b00 : ctl_alusrcb;
  assign aluop     = rst ? 4'b0000 : ctl_aluop;
  assign extop     = !rst && ctl_extop;
  assign luiop     = !rst && ctl_luiop;
  assign retired   = rst ? '0 : retired_q;
  assign halted    = !rst && (state_q == StHalt);
  assign mem_err   = !rst && mem_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal   = !rst && illegal_q;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (MEM_TIMEOUT=4, CNT_W=4).
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ack;
  logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pcsrc, regdst, alusrca, alusrcb;
  logic       reg_write, memtoreg, extop, luiop;
  logic [3:0] aluop;
  logic [3:0] retired;
  logic       halted, mem_err, illegal;

  int n_total = 0;
  int n_bad   = 0;
  int exp_ret = 0;

  logic [28:0] all_outs;
  assign all_outs = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pcsrc, reg_write,
                     regdst, memtoreg, alusrca, alusrcb, aluop, extop, luiop, retired, halted,
                     mem_err, illegal};

  mc_ctrl_fsm #(
    .MEM_TIMEOUT(4),
    .TO_W       (8),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .funct    (funct),
    .alu_zero (alu_zero),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .iord     (iord),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .pcsrc    (pcsrc),
    .reg_write(reg_write),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .extop    (extop),
    .luiop    (luiop),
    .retired  (retired),
    .halted   (halted),
    .mem_err  (mem_err),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One FETCH cycle with immediate ack; returns settled in DECODE.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode  = op;
    funct   = fn;
    mem_ack = 1'b1;
    #1;
    check("fetch_ctl", {mem_req, mem_read, iord, ir_write, pc_write, pcsrc, alusrcb},
          {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b11});
    tick();
    mem_ack = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    mem_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_ret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ack = 1'b0;
    tick();
    check("rst_zero", {3'b0, all_outs}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst", {mem_req, iord, alusrcb, pcsrc, retired, halted},
          {1'b1, 1'b1, 2'b11, 2'b01, 4'd0, 1'b0});

    // add: FETCH/DECODE/EXEC_R/WB_R
    fetch(6'h00, 6'h20);
    check("add_dec", {alusrca, alusrcb, aluop, extop}, {2'b00, 2'b10, 4'b0000, 1'b1});
    tick();
    check("add_exec", {alusrca, alusrcb, aluop}, {2'b11, 2'b00, 4'b0010});
    tick();
    check("add_wb", {reg_write, regdst, memtoreg}, {1'b1, 2'b10, 1'b0});
    tick();
    exp_ret = 1;
    check("add_ret", retired, exp_ret);

    // sll uses shamt on port A
    fetch(6'h00, 6'h00);
    tick();
    check("sll_exec", alusrca, 2'b01);
    tick();
    tick();
    exp_ret = 2;
    check("sll_ret", retired, exp_ret);

    // lw with ack on the 4th MEM_ACC cycle (also the last cycle before timeout)
    fetch(6'h23, 6'h00);
    tick();
    check("lw_addr", {alusrca, alusrcb, extop, aluop}, {2'b11, 2'b01, 1'b1, 4'b0000});
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      check("lw_acc", {mem_req, iord, mem_read, mem_write, alusrca, alusrcb, extop, aluop},
            {1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 1'b1, 4'b0000});
      tick();
    end
    mem_ack = 1'b0;
    #1;
    check("lw_wb", {reg_write, regdst, memtoreg, mem_err}, {1'b1, 2'b01, 1'b1, 1'b0});
    tick();
    exp_ret = 3;
    check("lw_ret", {retired, mem_req}, {4'(exp_ret), 1'b1});

    // sw with immediate ack retires straight from MEM_ACC
    fetch(6'h2B, 6'h00);
    tick();
    tick();
    mem_ack = 1'b1;
    #1;
    check("sw_acc", {mem_write, mem_read, iord}, {1'b1, 1'b0, 1'b0});
    tick();
    mem_ack = 1'b0;
    #1;
    exp_ret = 4;
    check("sw_ret", retired, exp_ret);

    // beq taken, bne not taken with alu_zero=1
    fetch(6'h04, 6'h00);
    tick();
    alu_zero = 1'b1;
    #1;
    check("beq", {pc_write, pcsrc, aluop}, {1'b1, 2'b00, 4'b0001});
    tick();
    fetch(6'h05, 6'h00);
    tick();
    #1;
    check("bne", {pc_write, pcsrc, aluop}, {1'b0, 2'b00, 4'b0001});
    tick();
    alu_zero = 1'b0;
    #1;
    exp_ret = 6;
    check("br_ret", retired, exp_ret);

    // ori zero-extends; lui shifts
    fetch(6'h0D, 6'h00);
    tick();
    check("ori_exec", {alusrca, alusrcb, extop, luiop, aluop}, {2'b11, 2'b01, 1'b0, 1'b0, 4'b0100});
    tick();
    check("ori_wb", {reg_write, regdst, memtoreg}, {1'b1, 2'b01, 1'b0});
    tick();
    fetch(6'h0F, 6'h00);
    tick();
    check("lui_exec", {alusrca, alusrcb, extop, luiop, aluop}, {2'b11, 2'b01, 1'b1, 1'b1, 4'b0111});
    tick();
    tick();
    exp_ret = 8;
    check("imm_ret", retired, exp_ret);

    // jal retires from DECODE
    fetch(6'h03, 6'h00);
    check("jal_dec", {pc_write, pcsrc, reg_write, regdst, memtoreg},
          {1'b1, 2'b11, 1'b1, 2'b00, 1'b0});
    tick();
    exp_ret = 9;
    check("jal_ret", retired, exp_ret);

    // 7 jumps wrap the 4-bit counter from 15 to 0
    for (int i = 0; i < 7; i++) begin
      fetch(6'h02, 6'h00);
      tick();
    end
    exp_ret = 0;
    check("ret_wrap", retired, exp_ret);

    // reset asserted mid-FETCH drops every output at once
    tick();
    rst = 1'b1;
    #1;
    check("rst_force", {3'b0, all_outs}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_release", {mem_req, iord, alusrcb, pcsrc, retired},
          {1'b1, 1'b1, 2'b11, 2'b01, 4'd0});

    // no ack for 4 FETCH cycles -> HALT with mem_err
    for (int i = 0; i < 4; i++) begin
      check("to_req", {halted, mem_req}, {1'b0, 1'b1});
      tick();
      #1;
    end
    check("to_halt", {halted, mem_err, retired, mem_req}, {1'b1, 1'b1, 4'd0, 1'b0});
    tick();
    check("halt_stays", {halted, mem_req, pc_write}, {1'b1, 1'b0, 1'b0});

    // illegal opcode 3F
    do_reset();
    check("clr_err", {mem_err, halted}, 2'b00);
    fetch(6'h3F, 6'h00);
    check("ill_dec", {pc_write, reg_write}, 2'b00);
    tick();
`ifdef MC_ILLEGAL_TRAP_EN
    check("ill_trap", {halted, illegal, retired, mem_req}, {1'b1, 1'b1, 4'd0, 1'b0});
`else
    check("ill_nop", {halted, illegal, retired, mem_req}, {1'b0, 1'b0, 4'd1, 1'b1});
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
